// File: rtl/cic3_row_stream.sv
// Row of NUM_CH third-order CIC decimators sharing one clock-enable strobe.
// Each produced frame is snapshotted and streamed one channel per valid/ready transfer.
module cic3_row_stream #(
  parameter int NUM_CH       = 24,
  parameter int DEC_LOG2_MAX = 8,
  parameter int ACC_W        = 3*DEC_LOG2_MAX+1,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int DL_W         = $clog2(DEC_LOG2_MAX+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] in,
  input  logic              enable,
  input  logic [DL_W-1:0]   dec_log2,
  output logic [ACC_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         idx_q, idx_d;
  logic                    en_q;
  logic [DL_W-1:0]         rlog2_q;
  logic [DEC_LOG2_MAX-1:0] dcnt_q;
  logic [1:0]              warm_q;
  logic                    overrun_q;
  logic [7:0]              drop_q;
  logic [NUM_CH-1:0]       in_q;
  logic [ACC_W-1:0]        i1_q [NUM_CH];
  logic [ACC_W-1:0]        i2_q [NUM_CH];
  logic [ACC_W-1:0]        i3_q [NUM_CH];
  logic [ACC_W-1:0]        d1_q [NUM_CH];
  logic [ACC_W-1:0]        d2_q [NUM_CH];
  logic [ACC_W-1:0]        d3_q [NUM_CH];
  logic [ACC_W-1:0]        snap_q [NUM_CH];
  logic [ACC_W-1:0]        c1_s [NUM_CH];
  logic [ACC_W-1:0]        c2_s [NUM_CH];
  logic [ACC_W-1:0]        c3_s [NUM_CH];

  logic                    rise_s, strobe_s, produce_s, load_s, drop_s;
  logic [DL_W-1:0]         cfg_s, r_cur_s;
  logic [DEC_LOG2_MAX-1:0] rmask_s;

  // Ratio applies on the rising-edge cycle itself, so the compare uses the value being captured.
  assign cfg_s     = (dec_log2 > DL_W'(DEC_LOG2_MAX)) ? DL_W'(DEC_LOG2_MAX) : dec_log2;
  assign rise_s    = enable & ~en_q;
  assign r_cur_s   = rise_s ? cfg_s : rlog2_q;
  assign rmask_s   = ~({DEC_LOG2_MAX{1'b1}} << r_cur_s);
  assign strobe_s  = enable & (dcnt_q == rmask_s);
  assign produce_s = strobe_s & (warm_q == 2'd3);
  assign load_s    = produce_s & (state_q == IDLE);
  assign drop_s    = produce_s & (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      rlog2_q   <= '0;
      dcnt_q    <= '0;
      warm_q    <= 2'd0;
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      en_q <= enable;
      if (rise_s) rlog2_q <= cfg_s;
      if (!enable) begin
        dcnt_q <= '0;
        warm_q <= 2'd0;
      end else if (strobe_s) begin
        dcnt_q <= '0;
        if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      end else begin
        dcnt_q <= dcnt_q + {{(DEC_LOG2_MAX-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        overrun_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      c1_s[k] = i3_q[k] - d1_q[k];
      c2_s[k] = c1_s[k] - d2_q[k];
      c3_s[k] = c2_s[k] - d3_q[k];
    end
  end

  // Integrators and comb delays; disabling the filter clears them, the snapshot is kept.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      in_q <= '0;
      i1_q <= '{default: '0};
      i2_q <= '{default: '0};
      i3_q <= '{default: '0};
      d1_q <= '{default: '0};
      d2_q <= '{default: '0};
      d3_q <= '{default: '0};
    end else begin
      in_q <= in;
      for (int k = 0; k < NUM_CH; k++) begin
        i1_q[k] <= i1_q[k] + {{(ACC_W-1){1'b0}}, in_q[k]};
        i2_q[k] <= i2_q[k] + i1_q[k];
        i3_q[k] <= i3_q[k] + i2_q[k];
        if (strobe_s) begin
          d1_q[k] <= i3_q[k];
          d2_q[k] <= c1_s[k];
          d3_q[k] <= c2_s[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) snap_q <= '{default: '0};
    else if (load_s) snap_q <= c3_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (load_s) begin
          state_d = SEND;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready && (idx_q == CH_W'(NUM_CH-1))) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (out_ready) begin
          idx_d = idx_q + {{(CH_W-1){1'b0}}, 1'b1};
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == SEND);
    out_ch    = idx_q;
    out_last  = out_valid & (idx_q == CH_W'(NUM_CH-1));
    if (out_valid) out_data = snap_q[idx_q];
    else out_data = '0;
    overrun   = overrun_q;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_cic3_row_stream.sv
// Directed bench for cic3_row_stream: warm-up, latency, settled values, drops, stalls, reset, config capture.
module tb_cic3_row_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in = 24'd0;
  logic        enable = 1'b0;
  logic [3:0]  dec_log2 = 4'd0;
  logic [24:0] out_data;
  logic [4:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [24:0] q_data[$];
  logic [4:0]  q_ch[$];
  logic        q_last[$];
  int          q_cyc[$];

  cic3_row_stream dut (
    .clk(clk), .reset(reset), .in(in), .enable(enable), .dec_log2(dec_log2),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Records accepted transfers until n are seen or the cycle budget runs out.
  task automatic capture(input int n, input int budget);
    int got = 0;
    int c = 0;
    q_data.delete(); q_ch.delete(); q_last.delete(); q_cyc.delete();
    while (got < n && c < budget) begin
      @(posedge clk); #1; c++;
      out_ready = 1'b1;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data); q_ch.push_back(out_ch);
        q_last.push_back(out_last); q_cyc.push_back(cyc);
        got++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; in = 24'hFFFFFF;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
    total++; if (out_data !== 25'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    total++; if (out_ch !== 5'd0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_ch got=%0d/%0d exp=0/0", out_ch, out_last); end
    total++; if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_overrun got=%0d/%0d exp=0/0", overrun, drop_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_warmup_ones();
    int e;
    do_reset();
    in = 24'hFFFFFF; dec_log2 = 4'd4; enable = 1'b1; e = cyc;
    capture(48, 300);
    total++; if (q_data.size() != 48) begin bad++; $display("FAIL t1_count got=%0d exp=48", q_data.size()); end
    if (q_cyc.size() == 48) begin
      total++; if (q_cyc[0] - e != 64) begin bad++; $display("FAIL t1_latency got=%0d exp=64", q_cyc[0] - e); end
      total++; if (q_cyc[24] - e != 96) begin bad++; $display("FAIL t1_frame2_start got=%0d exp=96", q_cyc[24] - e); end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++; if (q_data[i] !== 25'd4096) begin bad++; $display("FAIL t1_data[%0d] got=%0d exp=4096", i, q_data[i]); end
      total++;
      if (q_ch[i] !== 5'(i % 24) || q_last[i] !== ((i % 24) == 23)) begin
        bad++; $display("FAIL t1_ch[%0d] got=%0d/%0d exp=%0d/%0d", i, q_ch[i], q_last[i], i % 24, (i % 24) == 23);
      end
    end
    total++; if (drop_cnt !== 8'd2 || overrun !== 1'b1) begin bad++; $display("FAIL t1_drops got=%0d/%0d exp=2/1", drop_cnt, overrun); end
  endtask

  task automatic test_alternating();
    int e;
    do_reset();
    in = 24'hAAAAAA; dec_log2 = 4'd8; enable = 1'b1; e = cyc;
    capture(24, 1200);
    total++; if (q_data.size() != 24) begin bad++; $display("FAIL t2_count got=%0d exp=24", q_data.size()); end
    if (q_cyc.size() == 24) begin
      total++; if (q_cyc[0] - e != 1024) begin bad++; $display("FAIL t2_latency got=%0d exp=1024", q_cyc[0] - e); end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== ((i % 2 == 1) ? 25'd16777216 : 25'd0)) begin
        bad++; $display("FAIL t2_data[%0d] got=%0d exp=%0d", i, q_data[i], (i % 2 == 1) ? 16777216 : 0);
      end
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL t2_overrun got=%0d exp=0", overrun); end
  endtask

  task automatic test_overrun();
    int e;
    do_reset();
    in = 24'hFFFFFF; dec_log2 = 4'd3; enable = 1'b1; e = cyc;
    capture(48, 200);
    total++; if (q_data.size() != 48) begin bad++; $display("FAIL t3_count got=%0d exp=48", q_data.size()); end
    if (q_cyc.size() == 48) begin
      total++; if (q_cyc[24] - e != 64) begin bad++; $display("FAIL t3_frame2_start got=%0d exp=64", q_cyc[24] - e); end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++; if (q_data[i] !== 25'd512) begin bad++; $display("FAIL t3_data[%0d] got=%0d exp=512", i, q_data[i]); end
    end
    total++; if (drop_cnt !== 8'd5 || overrun !== 1'b1) begin bad++; $display("FAIL t3_drops got=%0d/%0d exp=5/1", drop_cnt, overrun); end
    step(3000);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL t3_saturate got=%0d exp=255", drop_cnt); end
    step(200);
    total++; if (drop_cnt !== 8'd255 || overrun !== 1'b1) begin bad++; $display("FAIL t3_hold got=%0d/%0d exp=255/1", drop_cnt, overrun); end
  endtask

  task automatic test_stall();
    int got = 0;
    int c = 0;
    int exp_ch = 0;
    logic stalled = 1'b0;
    logic [24:0] pd = 25'd0;
    logic [4:0]  pc = 5'd0;
    do_reset();
    in = 24'hFFFFFF; dec_log2 = 4'd4; enable = 1'b1;
    while (got < 72 && c < 5000) begin
      @(posedge clk); #1; c++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc) begin
          bad++; $display("FAIL t4_hold got=%0d/%0d/%0d exp=1/%0d/%0d", out_valid, out_data, out_ch, pd, pc);
        end
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        total++; if (out_data !== 25'd4096) begin bad++; $display("FAIL t4_data got=%0d exp=4096", out_data); end
        total++;
        if (out_ch !== 5'(exp_ch) || out_last !== (exp_ch == 23)) begin
          bad++; $display("FAIL t4_seq got=%0d/%0d exp=%0d/%0d", out_ch, out_last, exp_ch, exp_ch == 23);
        end
        exp_ch = (exp_ch == 23) ? 0 : exp_ch + 1;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid; pd = out_data; pc = out_ch;
      end
    end
    total++; if (got != 72) begin bad++; $display("FAIL t4_count got=%0d exp=72", got); end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    int e;
    do_reset();
    in = 24'hFFFFFF; dec_log2 = 4'd4; enable = 1'b1; out_ready = 1'b1;
    while (!(out_valid && out_ch == 5'd5 && overrun) && c < 300) begin
      @(posedge clk); #1; c++;
    end
    total++; if (out_ch !== 5'd5 || overrun !== 1'b1 || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL t5_setup got=%0d/%0d/%0d exp=5/1/1", out_ch, overrun, drop_cnt);
    end
    reset = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 25'd0) begin bad++; $display("FAIL t5_valid got=%0d/%0d exp=0/0", out_valid, out_data); end
    total++; if (overrun !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL t5_overrun got=%0d/%0d exp=0/0", overrun, drop_cnt); end
    reset = 1'b0; enable = 1'b1; e = cyc;
    capture(24, 300);
    total++; if (q_data.size() != 24) begin bad++; $display("FAIL t5_count got=%0d exp=24", q_data.size()); end
    if (q_cyc.size() == 24) begin
      total++; if (q_cyc[0] - e != 64) begin bad++; $display("FAIL t5_latency got=%0d exp=64", q_cyc[0] - e); end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++; if (q_data[i] !== 25'd4096 || q_ch[i] !== 5'(i)) begin
        bad++; $display("FAIL t5_data[%0d] got=%0d/%0d exp=4096/%0d", i, q_data[i], q_ch[i], i);
      end
    end
  endtask

  task automatic test_config_capture();
    int e;
    do_reset();
    in = 24'hFFFFFF; dec_log2 = 4'd4; enable = 1'b1; e = cyc;
    step(10);
    dec_log2 = 4'd6;
    capture(24, 300);
    total++; if (q_data.size() != 24) begin bad++; $display("FAIL t6_count1 got=%0d exp=24", q_data.size()); end
    if (q_cyc.size() == 24) begin
      total++; if (q_cyc[0] - e != 64) begin bad++; $display("FAIL t6_latency1 got=%0d exp=64", q_cyc[0] - e); end
      total++; if (q_data[0] !== 25'd4096) begin bad++; $display("FAIL t6_data1 got=%0d exp=4096", q_data[0]); end
    end
    enable = 1'b0;
    step(3);
    enable = 1'b1; e = cyc;
    capture(24, 600);
    total++; if (q_data.size() != 24) begin bad++; $display("FAIL t6_count2 got=%0d exp=24", q_data.size()); end
    if (q_cyc.size() == 24) begin
      total++; if (q_cyc[0] - e != 256) begin bad++; $display("FAIL t6_latency2 got=%0d exp=256", q_cyc[0] - e); end
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++; if (q_data[i] !== 25'd262144) begin bad++; $display("FAIL t6_data2[%0d] got=%0d exp=262144", i, q_data[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_warmup_ones();
    test_alternating();
    test_overrun();
    test_stall();
    test_mid_reset();
    test_config_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
